// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: sll / srl / sra / ror with carry-out and zero flag.
// One register stage per shift-amount bit; stage k shifts by 2^k when amt[k]=1.
// A single global advance signal stalls every stage at once under backpressure.
module pipelined_barrel_shifter #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             out_zero
);

   localparam logic [1:0]     MODE_SLL = 2'b00;
   localparam logic [1:0]     MODE_SRL = 2'b01;
   localparam logic [1:0]     MODE_SRA = 2'b10;
   localparam logic [SHW-1:0] AMT_ONE  = SHW'(1);

   // Per-stage registers (index k = output of stage k).
   logic [SHW-1:0][WIDTH-1:0] data_q, orig_q;
   logic [SHW-1:0][SHW-1:0]   amt_q;
   logic [SHW-1:0][1:0]       mode_q;
   logic [SHW-1:0]            vld_q;

   // Stage inputs: stage 0 reads the input port, stage k reads stage k-1.
   logic [SHW-1:0][WIDTH-1:0] src_data, src_orig, nxt_data;
   logic [SHW-1:0][SHW-1:0]   src_amt;
   logic [SHW-1:0][1:0]       src_mode;
   logic [SHW-1:0]            src_vld;

   logic             advance;
   logic [SHW-1:0]   amt_f, cidx;

   // Shift of a fixed power-of-two distance; stages compose into the full shift.
   function automatic logic [WIDTH-1:0] step_shift(input logic [WIDTH-1:0] d,
                                                   input logic [1:0] m,
                                                   input int s);
      logic [WIDTH-1:0] r;
      case (m)
         MODE_SLL: r = d << s;
         MODE_SRL: r = d >> s;
         MODE_SRA: r = $unsigned($signed(d) >>> s);
         default:  r = (d >> s) | (d << (WIDTH - s));
      endcase
      return r;
   endfunction

   // The whole pipe moves together; in_ready never looks at in_valid.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   assign src_data = {data_q[SHW-2:0], in_data};
   assign src_orig = {orig_q[SHW-2:0], in_data};
   assign src_amt  = {amt_q[SHW-2:0],  in_amt};
   assign src_mode = {mode_q[SHW-2:0], in_mode};
   assign src_vld  = {vld_q[SHW-2:0],  in_valid};

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      assign nxt_data[k] = src_amt[k][k] ? step_shift(src_data[k], src_mode[k], 1 << k)
                                         : src_data[k];
   end

   // Pipeline registers: load on advance, otherwise hold every stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         data_q <= '0;
         orig_q <= '0;
         amt_q  <= '0;
         mode_q <= '0;
      end else if (advance) begin
         vld_q  <= src_vld;
         data_q <= nxt_data;
         orig_q <= src_orig;
         amt_q  <= src_amt;
         mode_q <= src_mode;
      end
   end

   assign out_valid = vld_q[SHW-1];
   assign out_data  = data_q[SHW-1];
   assign out_zero  = out_valid && (out_data == '0);
   assign amt_f     = amt_q[SHW-1];

   // Last bit shifted out, picked from the untouched operand carried to the end:
   // left shift loses a[WIDTH-n], right shifts and rotate lose a[n-1].
   always_comb begin
      cidx      = (mode_q[SHW-1] == MODE_SLL) ? ('0 - amt_f) : (amt_f - AMT_ONE);
      out_carry = (amt_f != '0) && orig_q[SHW-1][cidx];
   end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench: directed vectors, back-to-back, backpressure, mid-flight
// reset, randomized stream vs. a behavioural model, plus an 8-bit instance.
module tb_pipelined_barrel_shifter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // 32-bit instance
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_carry, a_out_zero;
   logic [31:0] a_in_data, a_out_data;
   logic [4:0]  a_in_amt;
   logic [1:0]  a_in_mode;

   // 8-bit instance
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_carry, b_out_zero;
   logic [7:0]  b_in_data, b_out_data;
   logic [2:0]  b_in_amt;
   logic [1:0]  b_in_mode;

   int tests = 0;
   int fails = 0;

   pipelined_barrel_shifter #(.WIDTH(32)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .in_amt(a_in_amt), .in_mode(a_in_mode),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_carry(a_out_carry), .out_zero(a_out_zero));

   pipelined_barrel_shifter #(.WIDTH(8)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_amt(b_in_amt), .in_mode(b_in_mode),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_carry(b_out_carry), .out_zero(b_out_zero));

   always #5 clk = ~clk;

   // Behavioural model: returns {carry, data} for a w-bit operand.
   function automatic logic [32:0] ref_op(input int w, input logic [31:0] a,
                                          input int n, input logic [1:0] m);
      logic [63:0] mask, aa, r;
      logic        c;
      mask = (64'd1 << w) - 64'd1;
      aa   = {32'd0, a} & mask;
      r    = aa;
      c    = 1'b0;
      if (n != 0) begin
         case (m)
            2'd0: begin r = (aa << n) & mask; c = aa[w-n]; end
            2'd1: begin r = aa >> n; c = aa[n-1]; end
            2'd2: begin
               r = aa >> n;
               if (aa[w-1]) r = r | (mask & ~(mask >> n));
               c = aa[n-1];
            end
            default: begin r = ((aa >> n) | (aa << (w - n))) & mask; c = aa[n-1]; end
         endcase
      end
      return {c, r[31:0]};
   endfunction

   task automatic drive_a(input logic v, input logic [1:0] m, input logic [31:0] d,
                          input logic [4:0] n);
      a_in_valid = v; a_in_mode = m; a_in_data = d; a_in_amt = n;
   endtask

   localparam logic [1:0]  DV_MODE [8] = '{2'd0, 2'd3, 2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
   localparam logic [31:0] DV_DATA [8] = '{32'h000000FE, 32'h0000000F, 32'h80000000, 32'h12345678,
                                           32'h80000001, 32'h00000003, 32'h80000000, 32'h00000003};
   localparam logic [4:0]  DV_AMT  [8] = '{5'd2, 5'd4, 5'd1, 5'd0, 5'd0, 5'd31, 5'd31, 5'd31};
   localparam logic [31:0] DV_EXP  [8] = '{32'h000003F8, 32'hF0000000, 32'h00000000, 32'h12345678,
                                           32'h80000001, 32'h80000000, 32'hFFFFFFFF, 32'h00000006};
   localparam logic        DV_CY   [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam logic        DV_ZR   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   task automatic test_reset();
      @(negedge clk);
      tests++;
      if (a_out_valid !== 1'b0 || a_out_data !== 32'd0 || a_out_carry !== 1'b0 ||
          a_out_zero !== 1'b0 || b_out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: got v=%b d=%h c=%b z=%b bv=%b, want all 0",
                  a_out_valid, a_out_data, a_out_carry, a_out_zero, b_out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      tests++;
      if (a_in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_in_ready: got %b, want 1", a_in_ready);
      end
   endtask

   task automatic test_directed();
      int lat;
      a_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive_a(1'b1, DV_MODE[i], DV_DATA[i], DV_AMT[i]);
         @(negedge clk);
         a_in_valid = 1'b0;
         lat = 1;
         while (!a_out_valid && lat < 20) begin @(negedge clk); lat++; end
         tests++;
         if (lat != 5 || a_out_valid !== 1'b1 || a_out_data !== DV_EXP[i] ||
             a_out_carry !== DV_CY[i] || a_out_zero !== DV_ZR[i]) begin
            fails++;
            $display("FAIL directed_%0d: got lat=%0d v=%b d=%h c=%b z=%b, want lat=5 d=%h c=%b z=%b",
                     i, lat, a_out_valid, a_out_data, a_out_carry, a_out_zero,
                     DV_EXP[i], DV_CY[i], DV_ZR[i]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int lat;
      a_out_ready = 1'b1;
      drive_a(1'b1, 2'd1, 32'hAAAAFFFF, 5'd2);
      @(negedge clk);
      drive_a(1'b1, 2'd2, 32'hAAAAFFFF, 5'd2);
      @(negedge clk);
      a_in_valid = 1'b0;
      lat = 2;
      while (!a_out_valid && lat < 20) begin @(negedge clk); lat++; end
      tests++;
      if (lat != 5 || a_out_data !== 32'h2AAABFFF || a_out_carry !== 1'b1) begin
         fails++;
         $display("FAIL b2b_srl: got lat=%0d d=%h c=%b, want lat=5 d=2aaabfff c=1",
                  lat, a_out_data, a_out_carry);
      end
      @(negedge clk);
      tests++;
      if (a_out_valid !== 1'b1 || a_out_data !== 32'hEAAABFFF || a_out_carry !== 1'b1) begin
         fails++;
         $display("FAIL b2b_sra: got v=%b d=%h c=%b, want v=1 d=eaaabfff c=1",
                  a_out_valid, a_out_data, a_out_carry);
      end
      @(negedge clk);
      tests++;
      if (a_out_valid !== 1'b0) begin
         fails++;
         $display("FAIL b2b_tail: got out_valid=%b, want 0", a_out_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [32:0] exp [5];
      logic [31:0] d;
      logic [4:0]  n;
      logic [1:0]  m;
      logic [31:0] held;
      a_out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         d = $urandom; n = 5'($urandom_range(0, 31)); m = 2'($urandom_range(0, 3));
         exp[i] = ref_op(32, d, int'(n), m);
         drive_a(1'b1, m, d, n);
         @(negedge clk);
      end
      a_in_valid = 1'b0;
      held = a_out_data;
      for (int h = 0; h < 3; h++) begin
         tests++;
         if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_out_data !== held ||
             a_out_data !== exp[0][31:0]) begin
            fails++;
            $display("FAIL bp_hold_%0d: got v=%b rdy=%b d=%h, want v=1 rdy=0 d=%h",
                     h, a_out_valid, a_in_ready, a_out_data, exp[0][31:0]);
         end
         @(negedge clk);
      end
      a_out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (a_out_valid !== 1'b1 || {a_out_carry, a_out_data} !== exp[i]) begin
            fails++;
            $display("FAIL bp_drain_%0d: got v=%b c=%b d=%h, want v=1 c=%b d=%h",
                     i, a_out_valid, a_out_carry, a_out_data, exp[i][32], exp[i][31:0]);
         end
         @(negedge clk);
      end
      tests++;
      if (a_out_valid !== 1'b0) begin
         fails++;
         $display("FAIL bp_empty: got out_valid=%b, want 0", a_out_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic stale;
      int   lat;
      logic [32:0] e;
      a_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_a(1'b1, 2'd0, $urandom, 5'd3);
         @(negedge clk);
      end
      a_in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (a_out_valid !== 1'b0) begin
         fails++;
         $display("FAIL rst3_valid: got %b, want 0", a_out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      stale = 1'b0;
      for (int i = 0; i < 8; i++) begin @(negedge clk); if (a_out_valid) stale = 1'b1; end
      tests++;
      if (stale !== 1'b0) begin
         fails++;
         $display("FAIL rst3_stale: got stale result=%b, want 0", stale);
      end
      e = ref_op(32, 32'h00F0000F, 7, 2'd3);
      drive_a(1'b1, 2'd3, 32'h00F0000F, 5'd7);
      @(negedge clk);
      a_in_valid = 1'b0;
      lat = 1;
      while (!a_out_valid && lat < 20) begin @(negedge clk); lat++; end
      tests++;
      if (lat != 5 || {a_out_carry, a_out_data} !== e) begin
         fails++;
         $display("FAIL rst3_fresh: got lat=%0d c=%b d=%h, want lat=5 c=%b d=%h",
                  lat, a_out_carry, a_out_data, e[32], e[31:0]);
      end
      @(negedge clk);
      // Full, stalled pipe with a result showing: reset must drop it at once.
      a_out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_a(1'b1, 2'd1, 32'hFFFFFFFF, 5'd1);
         @(negedge clk);
      end
      a_in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (a_out_valid !== 1'b0 || a_out_data !== 32'd0 || a_out_carry !== 1'b0) begin
         fails++;
         $display("FAIL rst_full: got v=%b d=%h c=%b, want 0 0 0",
                  a_out_valid, a_out_data, a_out_carry);
      end
      @(negedge clk);
      rst_n = 1'b1;
      a_out_ready = 1'b1;
      stale = 1'b0;
      for (int i = 0; i < 8; i++) begin @(negedge clk); if (a_out_valid) stale = 1'b1; end
      tests++;
      if (stale !== 1'b0) begin
         fails++;
         $display("FAIL rst_full_stale: got stale result=%b, want 0", stale);
      end
   endtask

   task automatic test_random();
      logic [32:0] q[$];
      logic [32:0] e;
      logic        rdy, v, acc, held;
      logic [33:0] hold_val;
      logic [31:0] d;
      logic [4:0]  n;
      logic [1:0]  m;
      held = 1'b0;
      hold_val = '0;
      for (int cyc = 0; cyc < 400 + 20; cyc++) begin
         @(negedge clk);
         if (held) begin
            tests++;
            if (a_out_valid !== 1'b1 || {a_out_data, a_out_carry, a_out_zero} !== hold_val) begin
               fails++;
               $display("FAIL rand_stable: got v=%b d/c/z=%h, want v=1 d/c/z=%h",
                        a_out_valid, {a_out_data, a_out_carry, a_out_zero}, hold_val);
            end
         end
         rdy = (cyc >= 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
         a_out_ready = rdy;
         if (a_out_valid && rdy) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL rand_extra: got unexpected result d=%h, want none", a_out_data);
            end else begin
               e = q.pop_front();
               if ({a_out_carry, a_out_data} !== e || a_out_zero !== (e[31:0] == 32'd0)) begin
                  fails++;
                  $display("FAIL rand_result: got c=%b d=%h z=%b, want c=%b d=%h z=%b",
                           a_out_carry, a_out_data, a_out_zero, e[32], e[31:0],
                           e[31:0] == 32'd0);
               end
            end
         end
         held = a_out_valid && !rdy;
         hold_val = {a_out_data, a_out_carry, a_out_zero};
         acc = !a_out_valid || rdy;
         v = (cyc < 400) && ($urandom_range(0, 4) != 0);
         d = $urandom; n = 5'($urandom_range(0, 31)); m = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) d = 32'd0;
         drive_a(v, m, d, n);
         #1;
         tests++;
         if (a_in_ready !== acc) begin
            fails++;
            $display("FAIL rand_in_ready: got %b, want %b", a_in_ready, acc);
         end
         if (v && acc) q.push_back(ref_op(32, d, int'(n), m));
      end
      a_in_valid = 1'b0;
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL rand_lost: got %0d results missing, want 0", q.size());
      end
   endtask

   task automatic test_width8();
      int lat;
      logic [32:0] e;
      logic [7:0]  d;
      b_out_ready = 1'b1;
      for (int t = -1; t < 32; t++) begin
         @(negedge clk);
         if (t < 0) begin
            d = 8'h81; b_in_mode = 2'd3; b_in_amt = 3'd1;
         end else begin
            d = 8'($urandom); b_in_mode = 2'(t / 8); b_in_amt = 3'(t % 8);
         end
         e = ref_op(8, {24'd0, d}, int'(b_in_amt), b_in_mode);
         if (t < 0) e = {1'b1, 32'h000000C0};
         b_in_data = d;
         b_in_valid = 1'b1;
         @(negedge clk);
         b_in_valid = 1'b0;
         lat = 1;
         while (!b_out_valid && lat < 20) begin @(negedge clk); lat++; end
         tests++;
         if (lat != 3 || {b_out_carry, b_out_data} !== {e[32], e[7:0]} ||
             b_out_zero !== (e[7:0] == 8'd0)) begin
            fails++;
            $display("FAIL w8_%0d: got lat=%0d c=%b d=%h z=%b, want lat=3 c=%b d=%h z=%b",
                     t, lat, b_out_carry, b_out_data, b_out_zero, e[32], e[7:0],
                     e[7:0] == 8'd0);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      drive_a(1'b0, 2'd0, 32'd0, 5'd0);
      a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = '0; b_in_amt = '0; b_in_mode = '0;
      b_out_ready = 1'b1;
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_width8();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion by 500000ns, want finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, fully pipelined barrel shifter that succeeds the 32-bit combinational shifter. It supports any power-of-two data width and adds rotate-right, carry-out and zero flags. One pipeline stage per shift-amount bit, with valid/ready handshakes on both sides. It sits between the ALU operand mux and the writeback/result bus, and accepts one operation per clock.

Parameters:
- WIDTH, 32, data width in bits; must be a power of two, 8 or greater.
- SHW, $clog2(WIDTH), shift-amount width and pipeline depth. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation present on in_* this cycle.
- in_ready  output  1  shifter accepts the operation this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  SHW  shift amount, 0..WIDTH-1.
- in_mode  input  2  operation: 00 sll, 01 srl, 10 sra, 11 ror.
- out_valid  output  1  result present on out_*.
- out_ready  input  1  consumer takes the result this cycle.
- out_data  output  WIDTH  shifted result.
- out_carry  output  1  last bit shifted out; 0 when amt==0.
- out_zero  output  1  out_data == 0.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All stage valid bits clear; out_valid=0.
  - out_data=0, out_carry=0, out_zero=0.
  - in_ready=1 in the first cycle after release.
- Pipeline structure:
  - SHW register stages. Stage k applies a shift of 2^k when amt bit k is 1, otherwise it passes data through.
  - Each stage carries data, amt, mode, the original operand (needed for carry) and a valid bit.
- Latency: a result appears on out_* exactly SHW cycles after acceptance (5 for WIDTH=32), provided no stall occurs.
- Handshake:
  - Transfer in happens when in_valid && in_ready. Transfer out happens when out_valid && out_ready.
  - Global advance = !out_valid || out_ready.
  - in_ready = advance. This is combinational from out_ready and out_valid only, never from in_valid.
  - When advance=0, every stage register holds its value.
  - While out_valid=1 and out_ready=0, out_data, out_carry and out_zero stay stable.
  - Bubbles (in_valid=0 while advance=1) propagate as invalid stages; stage contents are don't-care when invalid.
- Throughput: one operation per cycle with out_ready held high. No bubbles are inserted between back-to-back operations.
- Arithmetic, with amt as an unsigned value n:
  - sll: a << n, zero fill. carry = a[WIDTH-n].
  - srl: a >> n, zero fill. carry = a[n-1].
  - sra: a >> n, fill with a[WIDTH-1]. carry = a[n-1].
  - ror: (a >> n) | (a << (WIDTH-n)). carry = a[n-1], which equals out_data[WIDTH-1].
  - n=0 for any mode: out_data=a, out_carry=0.
- out_zero is derived from the final-stage data register. It may be registered or combinational from that register, but it must be coherent with out_data whenever out_valid=1.
- Mid-operation reset: all in-flight operations are discarded and out_valid falls asynchronously. No partial result is emitted after release.
- Simultaneous events: in the same cycle as an output transfer, a new input may be accepted. The pipeline shifts by one with no loss or duplication.

Test Plan:
- WIDTH=32, sll, in_data=0x000000FE, amt=2 → 5 cycles later out_data=0x000003F8, carry=0, zero=0.
- WIDTH=32, srl then sra back to back, in_data=0xAAAAFFFF, amt=2:
  - srl → out_data=0x2AAABFFF, carry=1.
  - sra → out_data=0xEAAABFFF, carry=1.
  - The two results appear on consecutive cycles.
- WIDTH=32, ror, in_data=0x0000000F, amt=4 → out_data=0xF0000000, carry=1. Also sll of 0x80000000 by 1 → out_data=0, carry=1, zero=1. Also any mode with amt=0 → out_data=in_data, carry=0.
- Backpressure:
  - Fill the pipeline with 5 ops, then hold out_ready=0 for 3 cycles.
  - Required: in_ready=0, out_data stable, no op lost.
  - Release: 5 results emerge in order, one per cycle.
- Reset mid-flight: assert rst_n=0 with 3 ops in flight → out_valid=0 immediately. After release, no stale results appear; a fresh op returns after SHW cycles.
- WIDTH=8 instance (SHW=3), ror, in_data=0x81, amt=1 → out_data=0xC0, carry=1, latency 3 cycles.
